// File: rtl/elink_tx_pkg.sv
// Shared constants and state encoding for the e-link transmit frame scheduler.
package elink_tx_pkg;

   localparam logic [7:0] SOF_BYTE   = 8'h3C;
   localparam logic [7:0] EOF_BYTE   = 8'hDC;
   localparam logic [7:0] IDLE_BYTE  = 8'h55;
   localparam logic [7:0] ABORT_BYTE = 8'hFD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      EOF  = 2'd2
   } state_e;

   function automatic logic [2:0] rr_next(input logic [2:0] g, input int n);
      return ((int'(g) + 1) >= n) ? 3'd0 : g + 3'd1;
   endfunction

endpackage

// File: rtl/elink_tx_frame_scheduler_rr_arbiter.sv
// Round-robin first-valid search starting at rr_ptr_i, wrapping at N_REQ.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req_valid_i,
   input  logic [2:0]       rr_ptr_i,
   output logic [2:0]       grant_o,
   output logic             any_valid_o
);

   logic [7:0] valid_pad;
   logic [3:0] sum;

   assign valid_pad = 8'(req_valid_i);

   always_comb begin
      grant_o     = '0;
      any_valid_o = 1'b0;
      sum         = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_ptr_i} + 4'(k);
         if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
         if (!any_valid_o && valid_pad[sum[2:0]]) begin
            any_valid_o = 1'b1;
            grant_o     = sum[2:0];
         end
      end
   end

endmodule

// File: rtl/elink_tx_frame_scheduler.sv
// Frames round-robin requester byte streams (SOF/payload/EOF) onto a 2-bit
// LSB-first e-link; a new byte is chosen on every ser_cnt==3 boundary cycle.
module elink_tx_frame_scheduler
   import elink_tx_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int STALL_MAX = 16
) (
   input  logic               clk_tx,
   input  logic               reset,
   input  logic               tx_enable,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [1:0]         tx_elink2bit,
   output logic [2:0]         grant_id,
   output logic               busy,
   output logic               frame_done,
   output logic               frame_abort
);

   localparam int SW = $clog2(STALL_MAX + 1);

   state_e          state_q, state_d;
   logic [1:0]      ser_cnt_q;
   logic [7:0]      shreg_q, shreg_d;
   logic [1:0]      tx_q;
   logic [2:0]      rr_ptr_q, rr_ptr_d;
   logic [2:0]      grant_q, grant_d;
   logic [SW-1:0]   stall_q, stall_d, stall_inc;
   logic            done_q, done_d;
   logic            abort_q, abort_d;

   logic [2:0]      arb_grant;
   logic            arb_any;
   logic [7:0]      valid_pad, last_pad;
   logic [63:0]     data_pad;
   logic            g_valid, g_last;
   logic [7:0]      g_data;
   logic            boundary;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req_valid_i (req_valid),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (arb_grant),
      .any_valid_o (arb_any)
   );

   assign valid_pad = 8'(req_valid);
   assign last_pad  = 8'(req_last);
   assign data_pad  = 64'(req_data);
   assign g_valid   = valid_pad[grant_q];
   assign g_last    = last_pad[grant_q];
   assign g_data    = data_pad[{grant_q, 3'b000} +: 8];
   assign boundary  = (ser_cnt_q == 2'd3);
   assign stall_inc = stall_q + SW'(1);

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      stall_d   = stall_q;
      done_d    = 1'b0;
      abort_d   = 1'b0;
      req_ready = '0;
      if (boundary) begin
         case (state_q)
            IDLE: begin
               if (tx_enable && arb_any) begin
                  grant_d = arb_grant;
                  shreg_d = SOF_BYTE;
                  stall_d = '0;
                  state_d = DATA;
               end else begin
                  shreg_d = IDLE_BYTE;
               end
            end
            DATA: begin
               if (g_valid) begin
                  for (int i = 0; i < N_REQ; i++) req_ready[i] = (grant_q == 3'(i));
                  shreg_d = g_data;
                  stall_d = '0;
                  if (g_last) state_d = EOF;
               end else if (stall_inc == SW'(STALL_MAX)) begin
                  // The slot that would be the STALL_MAX-th idle carries ABORT instead.
                  shreg_d  = ABORT_BYTE;
                  abort_d  = 1'b1;
                  rr_ptr_d = rr_next(grant_q, N_REQ);
                  stall_d  = '0;
                  state_d  = IDLE;
               end else begin
                  shreg_d = IDLE_BYTE;
                  stall_d = stall_inc;
               end
            end
            EOF: begin
               shreg_d  = EOF_BYTE;
               done_d   = 1'b1;
               rr_ptr_d = rr_next(grant_q, N_REQ);
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_tx) begin
      if (reset) begin
         state_q   <= IDLE;
         ser_cnt_q <= '0;
         shreg_q   <= IDLE_BYTE;
         tx_q      <= '0;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         stall_q   <= '0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ser_cnt_q <= ser_cnt_q + 2'd1;
         shreg_q   <= shreg_d;
         tx_q      <= shreg_q[{ser_cnt_q, 1'b0} +: 2];
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         stall_q   <= stall_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
      end
   end

   assign tx_elink2bit = tx_q;
   assign grant_id     = grant_q;
   assign busy         = (state_q != IDLE);
   assign frame_done   = done_q;
   assign frame_abort  = abort_q;

endmodule

// File: tb/tb_elink_tx_frame_scheduler.sv
// Directed bench: requester queues drive the DUT, a monitor rebuilds link bytes.
module tb_elink_tx_frame_scheduler;

   localparam int N_REQ     = 4;
   localparam int STALL_MAX = 16;

   logic               clk_tx    = 1'b0;
   logic               reset     = 1'b1;
   logic               tx_enable = 1'b0;
   logic [N_REQ-1:0]   req_valid = '0;
   logic [8*N_REQ-1:0] req_data  = '0;
   logic [N_REQ-1:0]   req_last  = '0;
   logic [N_REQ-1:0]   req_ready;
   logic [1:0]         tx_elink2bit;
   logic [2:0]         grant_id;
   logic               busy, frame_done, frame_abort;

   always #5 clk_tx = ~clk_tx;

   elink_tx_frame_scheduler #(.N_REQ(N_REQ), .STALL_MAX(STALL_MAX)) dut (
      .clk_tx       (clk_tx),
      .reset        (reset),
      .tx_enable    (tx_enable),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .tx_elink2bit (tx_elink2bit),
      .grant_id     (grant_id),
      .busy         (busy),
      .frame_done   (frame_done),
      .frame_abort  (frame_abort)
   );

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         gap;
   } ent_t;

   ent_t       rq[N_REQ][$];
   logic [7:0] link_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] acc = 8'h00;
   logic [1:0] ph  = 2'd0;
   int         cyc = 0;
   int         n_done, n_abort, viol;
   int         rdy1_cyc[$];
   int         checks   = 0;
   int         failures = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l, input int g);
      ent_t e;
      e.data = d; e.last = l; e.gap = g;
      rq[r].push_back(e);
   endtask

   // One clock: sample link pair, drive requesters, then observe handshake.
   task automatic step();
      ent_t e;
      @(negedge clk_tx);
      cyc++;
      if (reset) begin
         ph = 2'd0;
         link_q.delete();
      end else begin
         acc = {tx_elink2bit, acc[7:2]};
         if (ph == 2'd3) link_q.push_back(acc);
         ph = ph + 2'd1;
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (reset || rq[i].size() == 0) begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            req_data[8*i +: 8] = 8'h00;
         end else begin
            e = rq[i][0];
            req_data[8*i +: 8] = e.data;
            req_last[i] = e.last;
            if (e.gap > 0) begin
               req_valid[i] = 1'b0;
               if (ph == 2'd3) begin
                  e.gap--;
                  rq[i][0] = e;
               end
            end else begin
               req_valid[i] = 1'b1;
            end
         end
      end
      #1;
      if ($countones(req_ready) > 1 || (req_ready != '0 && ph != 2'd3)) viol++;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            if (i == 1) rdy1_cyc.push_back(cyc);
            if (rq[i].size() > 0) void'(rq[i].pop_front());
         end
      end
      if (frame_done) n_done++;
      if (frame_abort) begin
         n_abort++;
         if (int'(grant_id) < N_REQ) rq[grant_id].delete();
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clr_stats();
      n_done = 0; n_abort = 0; viol = 0;
      rdy1_cyc.delete();
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      for (int i = 0; i < N_REQ; i++) rq[i].delete();
      step();
      chk_eq({tag, "_tx"},    32'(tx_elink2bit), 32'h0);
      chk_eq({tag, "_busy"},  32'(busy),         32'h0);
      chk_eq({tag, "_gid"},   32'(grant_id),     32'h0);
      chk_eq({tag, "_done"},  32'(frame_done),   32'h0);
      chk_eq({tag, "_abort"}, 32'(frame_abort),  32'h0);
      chk_eq({tag, "_rdy"},   32'(req_ready),    32'h0);
      step();
      reset = 1'b0;
   endtask

   // Compare captured link bytes against exp_q, skipping leading idle fill.
   task automatic expect_bytes(input string tag);
      int nonidle;
      while (link_q.size() > 0 && link_q[0] == 8'h55) void'(link_q.pop_front());
      for (int k = 0; k < exp_q.size(); k++) begin
         if (link_q.size() == 0) chk_eq($sformatf("%s[%0d]", tag, k), 32'h100, 32'(exp_q[k]));
         else chk_eq($sformatf("%s[%0d]", tag, k), 32'(link_q.pop_front()), 32'(exp_q[k]));
      end
      nonidle = 0;
      foreach (link_q[k]) if (link_q[k] != 8'h55) nonidle++;
      chk_eq({tag, "_trail"}, 32'(nonidle), 32'h0);
      link_q.delete();
   endtask

   task automatic wait_busy(input string tag);
      int k;
      k = 0;
      while (!busy && k < 40) begin step(); k++; end
      chk_eq(tag, 32'(busy), 32'h1);
   endtask

   initial begin
      clr_stats();

      // Idle link after reset
      do_reset("rst0");
      tx_enable = 1'b1;
      run(16);
      chk_eq("idle_nbytes", 32'(link_q.size()), 32'd4);
      foreach (link_q[k]) chk_eq($sformatf("idle_byte%0d", k), 32'(link_q[k]), 32'h55);
      chk_eq("idle_pair", 32'(tx_elink2bit), 32'h1);
      chk_eq("idle_busy", 32'(busy), 32'h0);
      link_q.delete();

      // Two-byte frame from requester 1
      do_reset("rst1");
      clr_stats();
      push(1, 8'hA1, 1'b0, 0);
      push(1, 8'hB2, 1'b1, 0);
      run(48);
      exp_q = '{8'h3C, 8'hA1, 8'hB2, 8'hDC};
      expect_bytes("f1");
      chk_eq("f1_done", 32'(n_done), 32'd1);
      chk_eq("f1_nrdy", 32'(rdy1_cyc.size()), 32'd2);
      if (rdy1_cyc.size() == 2) chk_eq("f1_rdy_gap", 32'(rdy1_cyc[1] - rdy1_cyc[0]), 32'd4);
      chk_eq("f1_gid", 32'(grant_id), 32'd1);
      chk_eq("f1_busy", 32'(busy), 32'h0);
      chk_eq("f1_viol", 32'(viol), 32'd0);

      // Round-robin between requesters 0 and 2
      do_reset("rst2");
      clr_stats();
      push(0, 8'h10, 1'b1, 0);
      push(0, 8'h11, 1'b1, 0);
      push(2, 8'h20, 1'b1, 0);
      push(2, 8'h21, 1'b1, 0);
      run(80);
      exp_q = '{8'h3C, 8'h10, 8'hDC, 8'h3C, 8'h20, 8'hDC,
                8'h3C, 8'h11, 8'hDC, 8'h3C, 8'h21, 8'hDC};
      expect_bytes("rr");
      chk_eq("rr_done", 32'(n_done), 32'd4);
      chk_eq("rr_viol", 32'(viol), 32'd0);

      // Short stall inside a frame
      do_reset("rst3");
      clr_stats();
      push(3, 8'hC1, 1'b0, 0);
      push(3, 8'hC2, 1'b0, 3);
      push(3, 8'hC3, 1'b1, 0);
      run(64);
      exp_q = '{8'h3C, 8'hC1, 8'h55, 8'h55, 8'h55, 8'hC2, 8'hC3, 8'hDC};
      expect_bytes("stall");
      chk_eq("stall_abort", 32'(n_abort), 32'd0);
      chk_eq("stall_done", 32'(n_done), 32'd1);
      chk_eq("stall_gid", 32'(grant_id), 32'd3);

      // Stall long enough to abort, then rr_ptr must point at requester 1
      do_reset("rst4");
      clr_stats();
      push(0, 8'hD1, 1'b0, 0);
      push(0, 8'hD2, 1'b1, 20);
      run(100);
      exp_q = '{8'h3C, 8'hD1};
      for (int k = 0; k < STALL_MAX - 1; k++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hFD);
      expect_bytes("abort");
      chk_eq("abort_cnt", 32'(n_abort), 32'd1);
      chk_eq("abort_done", 32'(n_done), 32'd0);
      chk_eq("abort_gid", 32'(grant_id), 32'd0);
      push(0, 8'hE0, 1'b1, 0);
      push(1, 8'hE1, 1'b1, 0);
      run(48);
      exp_q = '{8'h3C, 8'hE1, 8'hDC, 8'h3C, 8'hE0, 8'hDC};
      expect_bytes("post_abort");

      // tx_enable dropped mid-frame: frame completes, nothing new starts
      do_reset("rst5");
      clr_stats();
      push(2, 8'hF1, 1'b0, 0);
      push(2, 8'hF2, 1'b0, 0);
      push(2, 8'hF3, 1'b1, 0);
      wait_busy("en_busy");
      tx_enable = 1'b0;
      push(1, 8'h61, 1'b1, 0);
      run(80);
      exp_q = '{8'h3C, 8'hF1, 8'hF2, 8'hF3, 8'hDC};
      expect_bytes("en_low");
      chk_eq("en_low_busy", 32'(busy), 32'h0);
      chk_eq("en_low_gid", 32'(grant_id), 32'd2);
      chk_eq("en_low_done", 32'(n_done), 32'd1);

      // Reset in the middle of a frame from requester 1
      rq[1].delete();
      tx_enable = 1'b1;
      push(1, 8'h71, 1'b0, 0);
      push(1, 8'h72, 1'b0, 0);
      push(1, 8'h73, 1'b1, 0);
      wait_busy("mid_busy");
      clr_stats();
      run(6);
      do_reset("rst_mid");
      chk_eq("mid_done", 32'(n_done), 32'd0);
      chk_eq("mid_abort", 32'(n_abort), 32'd0);
      run(16);
      chk_eq("mid_nbytes", 32'(link_q.size()), 32'd4);
      foreach (link_q[k]) chk_eq($sformatf("mid_idle%0d", k), 32'(link_q[k]), 32'h55);
      chk_eq("mid_viol", 32'(viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
